// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// It holds one operation in flight. Single-cycle ops have one cycle of latency.
// Optional iterative shift-add multiplier (opcode 10), enabled by the macro SEQ_ALU_MUL_EN.
// Without the macro, opcode 10 is reported as an illegal opcode.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // Shift amounts at or above this value saturate (0 or all sign bits).
    localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);

    logic [1:0]       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SH_W-1:0]  w_shamt;
    logic             w_sh_big;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;

    // A new op may enter when nothing is held, or when the held result leaves this cycle.
    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    // ADD/SUB carry and borrow come from the extra top bit of a WIDTH+1 computation.
    assign w_sum    = {1'b0, operand1} + {1'b0, operand2};
    assign w_diff   = {1'b0, operand1} - {1'b0, operand2};
    assign w_shamt  = operand2[SH_W-1:0];
    assign w_sh_big = (operand2 >= W_LIMIT);

    // Single-cycle result and carry/overflow/error for the opcode presented at the input.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND: w_res = operand1 & operand2;
            OP_OR:  w_res = operand1 | operand2;
            OP_XOR: w_res = operand1 ^ operand2;
            OP_SLL: begin
                if (w_sh_big) w_res = {WIDTH{1'b0}};
                else          w_res = operand1 << w_shamt;
            end
            OP_SRL: begin
                if (w_sh_big) w_res = {WIDTH{1'b0}};
                else          w_res = operand1 >> w_shamt;
            end
            OP_SRA: begin
                if (w_sh_big) w_res = {WIDTH{operand1[WIDTH-1]}};
                else          w_res = $unsigned($signed(operand1) >>> w_shamt);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            // Illegal opcodes (and MUL when the multiplier is absent): result 0, err set.
            default: w_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0]       OP_MUL  = 4'd10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_is_mul;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_is_mul   = (opcode == OP_MUL);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Shift-add multiplier: the multiplicand moves left, the multiplier moves right, one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_accept && w_is_mul) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {{WIDTH{1'b0}}, operand1};
            r_mplier <= operand2;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1'b1;
            r_mplier <= r_mplier >> 1'b1;
            r_cnt    <= r_cnt - CNT_ONE;
        end else begin
            r_acc    <= r_acc;
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_cnt    <= r_cnt;
        end
    end
`endif

    // Control FSM plus registered result and flags. Z/N are registered together with the
    // result so that both read 0 after reset, as the other flags do.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
`ifdef SEQ_ALU_MUL_EN
                        if (w_is_mul) begin
                            r_state     <= ST_BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
`else
                        begin
`endif
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_flag_z    <= (w_res == {WIDTH{1'b0}});
                            r_flag_n    <= w_res[WIDTH-1];
                            r_flag_c    <= w_c;
                            r_flag_v    <= w_v;
                            r_err       <= w_err;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state     <= r_state;
                        r_out_valid <= r_out_valid;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                ST_BUSY: begin
                    // The last step's sum goes straight into the result register.
                    if (r_cnt == CNT_ONE) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_flag_z    <= (w_acc_next[WIDTH-1:0] == {WIDTH{1'b0}});
                        r_flag_n    <= w_acc_next[WIDTH-1];
                        r_flag_c    <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_flag_v    <= 1'b0;
                        r_err       <= 1'b0;
                    end else begin
                        r_state     <= ST_BUSY;
                        r_out_valid <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign err       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard testbench for seq_alu (WIDTH=16). The stimulus pushes the expected
// {result,Z,N,C,V,err} for each op. A separate monitor pops and compares an entry
// on every output handshake. Multiplier vectors run when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    int n_cmp  = 0;
    int n_fail = 0;
    int tot_waits = 0;

    logic [W+4:0] exp_q[$];
    string        name_q[$];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .err(err)
    );

    function automatic logic [W+4:0] mk(input logic [W-1:0] r, input logic z, input logic n,
                                        input logic c, input logic v, input logic e);
        return {r, z, n, c, v, e};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per output handshake.
    always @(negedge clk) begin : monitor
        logic [W+4:0] e;
        string        nm;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, 32'({result, flag_z, flag_n, flag_c, flag_v, err}), 32'(e));
            end
        end
    end

    // Drives one op until it is accepted. Entered either at posedge+1 (clk high)
    // or right at a negedge (clk low). The accept decision is made in the low phase.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+4:0] e, input string nm, input bit push,
                        output int waits);
        opcode   = op;
        operand1 = a;
        operand2 = b;
        in_valid = 1'b1;
        waits    = 0;
        if (clk) @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1 within 50 cycles", nm);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'hF;
        operand1 = 16'hDEAD;
        operand2 = 16'hBEEF;
    endtask

    task automatic vec(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W+4:0] e, input bit lat);
        int w;
        send(op, a, b, e, nm, 1'b1, w);
        tot_waits += w;
        if (lat) begin
            @(negedge clk);
            check({nm, "_latency"}, 32'(out_valid), 32'h1);
        end
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic mul_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W+4:0] e);
        int w;
        int cyc;
        int bad_rdy;
        send(4'd10, a, b, e, nm, 1'b1, w);
        cyc     = 0;
        bad_rdy = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) bad_rdy++;
            cyc++;
        end
        check({nm, "_latency"}, 32'(cyc), 32'd16);
        check({nm, "_in_ready_low"}, 32'(bad_rdy), 32'd0);
    endtask
`endif

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 4'd0;
        operand1  = 16'h0000;
        operand2  = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'({out_valid, result, flag_z, flag_n, flag_c, flag_v, err}), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

        // Basic ops, streamed back-to-back with out_ready high.
        vec("add_ovf",    4'd0,  16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        tot_waits = 0;
        vec("sub_borrow", 4'd1,  16'h0003, 16'h0005, mk(16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        vec("slt",        4'd8,  16'hFFFE, 16'h0001, mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("sltu",       4'd9,  16'hFFFE, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("sra_big",    4'd7,  16'h8000, 16'd20,   mk(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("srl_15",     4'd6,  16'h8000, 16'd15,   mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("sll_16",     4'd5,  16'h0001, 16'd16,   mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("and",        4'd2,  16'hF0F0, 16'h0FF0, mk(16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("or",         4'd3,  16'hF000, 16'h000F, mk(16'hF00F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("add_carry",  4'd0,  16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
        vec("sub_ovf",    4'd1,  16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        vec("sra_4",      4'd7,  16'h8000, 16'd4,    mk(16'hF800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("sll_4",      4'd5,  16'h0003, 16'd4,    mk(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("srl_big",    4'd6,  16'hFFFF, 16'h0100, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        vec("illegal_15", 4'd15, 16'h1234, 16'h5678, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        check("throughput_no_stall", 32'(tot_waits), 32'd0);

`ifdef SEQ_ALU_MUL_EN
        mul_chk("mul_basic", 16'h0123, 16'h0010, mk(16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        mul_chk("mul_hi",    16'h0100, 16'h0100, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        mul_chk("mul_ffff",  16'hFFFF, 16'hFFFF, mk(16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        vec("op10_illegal", 4'd10, 16'h0123, 16'h0010, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
`endif

        // Backpressure: the result is held while out_ready is low. The held result
        // then leaves on the same edge that accepts the next op.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(4'd0, 16'h1234, 16'h1111, mk(16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "bp_add", 1'b1, w);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", 32'({out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v, err}),
                  32'({1'b1, 1'b0, 16'h2345, 5'b00000}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'd4, 16'h00FF, 16'h0F0F, mk(16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "bp_xor", 1'b1, w);
        check("bp_same_edge_accept", 32'(w), 32'd0);
        @(negedge clk);
        check("bp_xor_latency", 32'(out_valid), 32'h1);
        vec("illegal_12", 4'd12, 16'hAAAA, 16'h5555, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);

        // Reset in the middle of an operation.
        @(posedge clk);
        #1;
`ifdef SEQ_ALU_MUL_EN
        send(4'd10, 16'h0123, 16'h0010, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mul_abort", 1'b0, w);
        repeat (4) @(posedge clk);
`else
        out_ready = 1'b0;
        send(4'd0, 16'h0001, 16'h0001, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "add_abort", 1'b0, w);
        @(negedge clk);
        check("abort_pre_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
`endif
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midop_reset_outputs", 32'({out_valid, result, flag_z, flag_n, flag_c, flag_v, err}), 32'h0);
        check("midop_reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        vec("add_after_reset", 4'd0, 16'h0002, 16'h0003, mk(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Adds valid/ready handshakes on input and output, registered status flags and arithmetic right shift.
- Adds signed and unsigned compares, illegal-opcode reporting, and an optional iterative multiplier.
- Sits between the register-stack operand fetch and writeback; holds one operation in flight.

Parameters:
- WIDTH, 16, datapath width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  ALU can accept; combinational: (state==IDLE) or (state==DONE and out_ready).
- opcode  in  4  operation select, sampled on accept.
- operand1  in  WIDTH  first operand, sampled on accept.
- operand2  in  WIDTH  second operand / shift amount, sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry (ADD), borrow (SUB), high half nonzero (MUL); else 0.
- flag_v  out  1  signed overflow (ADD/SUB only); else 0.
- err  out  1  illegal opcode.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, out_valid=0, result=0, all flags=0, err=0. in_ready=1 in the cycle after reset.
- Reset mid-multiply aborts the operation. No output is produced.
- Accept occurs at a rising edge with in_valid & in_ready. The opcode and operands are latched on accept; later input changes are ignored.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0).
  - 10 MUL.
  - 11-15 illegal.
- Shifts use the full operand2 value. If operand2 >= WIDTH: SLL/SRL give 0, SRA gives all sign bits.
- ADD/SUB are computed at WIDTH+1 bits.
  - C = bit WIDTH for ADD. C = borrow (op1 < op2 unsigned) for SUB.
  - V = operand signs equal and result sign differs (ADD). V = operand signs differ and result sign differs from op1 (SUB).
- Illegal opcode: result=0, err=1, C=V=0, Z=1. Same latency as single-cycle ops. err=0 for all legal ops.
- FSM:
  - IDLE: on accept of a single-cycle op, compute and register result/flags and go to DONE. On accept of MUL, load the multiplicand, multiplier and a zero accumulator, set the counter to WIDTH, and go to BUSY.
  - BUSY: one shift-add step per cycle with a 2*WIDTH-bit accumulator; counter decrements. When the counter reaches 0, register the low WIDTH bits as result, set C = (high half != 0), V=0, and go to DONE. in_ready=0.
  - DONE: out_valid=1; result and flags held stable while out_ready=0.
    - out_ready=1 and no accept: go to IDLE, out_valid falls.
    - out_ready=1 with a simultaneous accept: start the new op directly, with the same transitions as from IDLE. No bubble.
- Latency (accept edge to out_valid high): 1 cycle for single-cycle ops; WIDTH cycles for MUL.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high.
- Z and N are always computed from the registered result.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined: opcode 10 is MUL as above; BUSY state, counter and accumulator exist.
- Undefined: no multiplier logic and no BUSY state. Opcode 10 is treated as illegal (result 0, err=1, latency 1).

Test Plan:
- ADD 0x7FFF+0x0001 (WIDTH=16) -> result 0x8000, N=1, V=1, C=0, Z=0, err=0; out_valid 1 cycle after accept.
- SUB 0x0003-0x0005 -> 0xFFFE, C=1, N=1, V=0; SLT 0xFFFE,0x0001 -> 1; SLTU 0xFFFE,0x0001 -> 0.
- SRA 0x8000 by 20 -> 0xFFFF; SRL 0x8000 by 15 -> 0x0001; SLL 0x0001 by 16 -> 0x0000, Z=1.
- MUL 0x0123*0x0010 -> 0x1230, C=0, out_valid exactly 16 cycles after accept, in_ready=0 throughout. MUL 0x0100*0x0100 -> 0x0000, Z=1, C=1. Without SEQ_ALU_MUL_EN: opcode 10 -> err=1, result 0.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0x00FF,0x0F0F) -> accepted the same edge, next result 0x0FF0. Opcode 12 -> err=1, result 0.
- Assert reset for 1 cycle during BUSY at iteration 5 -> next cycle out_valid=0, result=0, flags=0, in_ready=1. A following ADD 2+3 -> 5.
